// File: rtl/ct_pmp_csr_pkg.sv
// rtl/ct_pmp_csr_pkg.sv - PMP CSR sequencer shared addresses, op codes, states and cfg field layout
package ct_pmp_csr_pkg;

   localparam logic [11:0] CSR_PMPCFG0    = 12'h3A0;
   localparam logic [11:0] CSR_PMPCFG2    = 12'h3A2;
   localparam logic [7:0]  CSR_PMPADDR_HI = 8'h3B;
   localparam logic [1:0]  PRIV_M         = 2'b11;

   typedef enum logic [1:0] {
      OP_RD = 2'b00,
      OP_RW = 2'b01,
      OP_RS = 2'b10,
      OP_RC = 2'b11
   } csr_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_CFG,
      ST_RD_CFG2,
      ST_RD_OLD,
      ST_WR,
      ST_RESP
   } seq_state_e;

   localparam int CFG_L    = 7;
   localparam int CFG_A_HI = 4;
   localparam int CFG_A_LO = 3;
   localparam int CFG_X    = 2;
   localparam int CFG_W    = 1;
   localparam int CFG_R    = 0;

   localparam logic [1:0] A_TOR = 2'b01;

   function automatic logic cfg_tor_locked(input logic [7:0] cfg);
      return cfg[CFG_L] && (cfg[CFG_A_HI:CFG_A_LO] == A_TOR);
   endfunction

endpackage

// File: rtl/ct_pmp_csr_merge.sv
// rtl/ct_pmp_csr_merge.sv - combinational CSRRW/RS/RC merge with pmpcfg WARL/lock and pmpaddr lock handling
module ct_pmp_csr_merge
   import ct_pmp_csr_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]      op,
   input  logic            is_cfg,
   input  logic            entry_locked,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] wdata
);
   logic [XLEN-1:0] new_val;
   logic [7:0]      old_byte;
   logic [7:0]      new_byte;

   always_comb begin
      new_val  = src;
      old_byte = '0;
      new_byte = '0;
      wdata    = old_val;
      case (csr_op_e'(op))
         OP_RS:   new_val = old_val | src;
         OP_RC:   new_val = old_val & ~src;
         default: new_val = src;
      endcase
      if (is_cfg) begin
         // Locked bytes and the reserved W=1,R=0 encoding both fall back to the old byte
         for (int b = 0; b < XLEN / 8; b++) begin
            old_byte = old_val[8*b +: 8];
            new_byte = new_val[8*b +: 8] & 8'h9F;
            if (old_byte[CFG_L] || (new_byte[CFG_W] && !new_byte[CFG_R]))
               wdata[8*b +: 8] = old_byte;
            else
               wdata[8*b +: 8] = new_byte;
         end
      end else if (!entry_locked) begin
         wdata = {{(XLEN-54){1'b0}}, new_val[53:0]};
      end
   end

endmodule

// File: rtl/ct_pmp_csr_seq.sv
// rtl/ct_pmp_csr_seq.sv - PMP CSR read-modify-write sequencer between the IU CSR pipe and the PMP top
// Optional CT_PMP_CSR_SEQ_TOR_LOCK_EN: pmpaddr i also protected by a locked TOR entry i+1.
module ct_pmp_csr_seq
   import ct_pmp_csr_pkg::*;
#(
   parameter int PMP_NUM = 8,
   parameter int XLEN    = 64
) (
   input  logic            forever_cpuclk,
   input  logic            cpurst_b,
   input  logic [1:0]      cp0_yy_priv_mode,
   input  logic            iu_csr_req_vld,
   output logic            csr_iu_req_rdy,
   input  logic [1:0]      iu_csr_op,
   input  logic [11:0]     iu_csr_addr,
   input  logic [XLEN-1:0] iu_csr_src,
   output logic            csr_iu_done_vld,
   output logic [XLEN-1:0] csr_iu_rdata,
   output logic            csr_iu_expt,
   output logic [4:0]      cp0_pmp_reg_num,
   output logic [XLEN-1:0] cp0_pmp_wdata,
   output logic            cp0_pmp_wreg,
   input  logic [XLEN-1:0] pmp_cp0_data
);
   seq_state_e      state;
   logic [1:0]      op_q;
   logic [11:0]     addr_q;
   logic [XLEN-1:0] src_q;
   logic [XLEN-1:0] old_q;
   logic            lock_q;

   logic            req_is_cfg;
   logic            req_is_addr;
   logic            req_legal;
   logic            is_addr_q;
   logic            addr_impl;
   logic [3:0]      idx;
   logic            own_lock;
   logic [XLEN-1:0] old_val;
   logic [XLEN-1:0] merged;

   assign req_is_cfg  = (iu_csr_addr == CSR_PMPCFG0) || (iu_csr_addr == CSR_PMPCFG2);
   assign req_is_addr = (iu_csr_addr[11:4] == CSR_PMPADDR_HI);
   assign req_legal   = (cp0_yy_priv_mode == PRIV_M) && (req_is_cfg || req_is_addr);

   assign is_addr_q = (addr_q[11:4] == CSR_PMPADDR_HI);
   assign idx       = addr_q[3:0];
   assign addr_impl = int'(idx) < PMP_NUM;
   assign own_lock  = pmp_cp0_data[{idx[2:0], 3'd7}];
   // Unimplemented pmpaddr entries read as zero regardless of what the PMP returns
   assign old_val   = (is_addr_q && !addr_impl) ? '0 : pmp_cp0_data;

`ifdef CT_PMP_CSR_SEQ_TOR_LOCK_EN
   logic [7:0] next_cfg;
   assign next_cfg = pmp_cp0_data[{idx[2:0] + 3'd1, 3'd0} +: 8];
`endif

   assign csr_iu_req_rdy = (state == ST_IDLE);

   ct_pmp_csr_merge #(.XLEN(XLEN)) u_merge (
      .op           (op_q),
      .is_cfg       (!is_addr_q),
      .entry_locked (lock_q),
      .old_val      (old_val),
      .src          (src_q),
      .wdata        (merged)
   );

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state           <= ST_IDLE;
         op_q            <= '0;
         addr_q          <= '0;
         src_q           <= '0;
         old_q           <= '0;
         lock_q          <= 1'b0;
         csr_iu_done_vld <= 1'b0;
         csr_iu_rdata    <= '0;
         csr_iu_expt     <= 1'b0;
         cp0_pmp_reg_num <= '0;
         cp0_pmp_wdata   <= '0;
         cp0_pmp_wreg    <= 1'b0;
      end else begin
         csr_iu_done_vld <= 1'b0;
         cp0_pmp_wreg    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iu_csr_req_vld) begin
                  op_q   <= iu_csr_op;
                  addr_q <= iu_csr_addr;
                  src_q  <= iu_csr_src;
                  lock_q <= 1'b0;
                  if (!req_legal) begin
                     state           <= ST_RESP;
                     csr_iu_done_vld <= 1'b1;
                     csr_iu_expt     <= 1'b1;
                     csr_iu_rdata    <= '0;
                  end else if (req_is_addr && (iu_csr_op != OP_RD)) begin
                     state           <= ST_RD_CFG;
                     cp0_pmp_reg_num <= iu_csr_addr[3] ? 5'h02 : 5'h00;
                  end else begin
                     state           <= ST_RD_OLD;
                     cp0_pmp_reg_num <= iu_csr_addr[4:0];
                  end
               end
            end
            ST_RD_CFG: begin
`ifdef CT_PMP_CSR_SEQ_TOR_LOCK_EN
               if (idx == 4'd7) begin
                  // Entry 8's cfg lives in pmpcfg2 byte 0, one more read away
                  lock_q          <= own_lock;
                  state           <= ST_RD_CFG2;
                  cp0_pmp_reg_num <= 5'h02;
               end else begin
                  lock_q          <= own_lock || cfg_tor_locked(next_cfg);
                  state           <= ST_RD_OLD;
                  cp0_pmp_reg_num <= addr_q[4:0];
               end
`else
               lock_q          <= own_lock;
               state           <= ST_RD_OLD;
               cp0_pmp_reg_num <= addr_q[4:0];
`endif
            end
            ST_RD_CFG2: begin
               lock_q          <= lock_q || cfg_tor_locked(pmp_cp0_data[7:0]);
               state           <= ST_RD_OLD;
               cp0_pmp_reg_num <= addr_q[4:0];
            end
            ST_RD_OLD: begin
               old_q <= old_val;
               if (op_q == OP_RD) begin
                  state           <= ST_RESP;
                  csr_iu_done_vld <= 1'b1;
                  csr_iu_expt     <= 1'b0;
                  csr_iu_rdata    <= old_val;
                  cp0_pmp_reg_num <= '0;
               end else begin
                  state         <= ST_WR;
                  cp0_pmp_wdata <= merged;
                  cp0_pmp_wreg  <= !(is_addr_q && !addr_impl);
               end
            end
            ST_WR: begin
               state           <= ST_RESP;
               csr_iu_done_vld <= 1'b1;
               csr_iu_expt     <= 1'b0;
               csr_iu_rdata    <= old_q;
               cp0_pmp_reg_num <= '0;
            end
            ST_RESP: begin
               state       <= ST_IDLE;
               csr_iu_expt <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_pmp_csr_seq.sv
// tb/tb_ct_pmp_csr_seq.sv - self-checking bench for ct_pmp_csr_seq against a byte-level PMP CSR model
module tb_ct_pmp_csr_seq;

   logic        forever_cpuclk;
   logic        cpurst_b;
   logic [1:0]  cp0_yy_priv_mode;
   logic        iu_csr_req_vld;
   logic        csr_iu_req_rdy;
   logic [1:0]  iu_csr_op;
   logic [11:0] iu_csr_addr;
   logic [63:0] iu_csr_src;
   logic        csr_iu_done_vld;
   logic [63:0] csr_iu_rdata;
   logic        csr_iu_expt;
   logic [4:0]  cp0_pmp_reg_num;
   logic [63:0] cp0_pmp_wdata;
   logic        cp0_pmp_wreg;
   logic [63:0] pmp_cp0_data;

   int n_checks = 0;
   int n_fail   = 0;
   int wreg_cnt = 0;

   // PMP register file seen by the DUT
   logic [63:0] f_cfg0, f_cfg2;
   logic [63:0] f_addr [8];

   // Reference model: one byte per entry cfg, one word per entry address
   logic [7:0]  m_cfg  [16];
   logic [63:0] m_addr [8];

   ct_pmp_csr_seq dut (
      .forever_cpuclk   (forever_cpuclk),
      .cpurst_b         (cpurst_b),
      .cp0_yy_priv_mode (cp0_yy_priv_mode),
      .iu_csr_req_vld   (iu_csr_req_vld),
      .csr_iu_req_rdy   (csr_iu_req_rdy),
      .iu_csr_op        (iu_csr_op),
      .iu_csr_addr      (iu_csr_addr),
      .iu_csr_src       (iu_csr_src),
      .csr_iu_done_vld  (csr_iu_done_vld),
      .csr_iu_rdata     (csr_iu_rdata),
      .csr_iu_expt      (csr_iu_expt),
      .cp0_pmp_reg_num  (cp0_pmp_reg_num),
      .cp0_pmp_wdata    (cp0_pmp_wdata),
      .cp0_pmp_wreg     (cp0_pmp_wreg),
      .pmp_cp0_data     (pmp_cp0_data)
   );

   initial begin
      forever_cpuclk = 1'b0;
      forever #5 forever_cpuclk = ~forever_cpuclk;
   end

   always_comb begin
      pmp_cp0_data = 64'h0;
      case (cp0_pmp_reg_num)
         5'h00: pmp_cp0_data = f_cfg0;
         5'h02: pmp_cp0_data = f_cfg2;
         default: begin
            if (cp0_pmp_reg_num[4:3] == 2'b10) pmp_cp0_data = f_addr[cp0_pmp_reg_num[2:0]];
            else if (cp0_pmp_reg_num[4:3] == 2'b11) pmp_cp0_data = 64'hA5A5_5A5A_DEAD_BEEF;
         end
      endcase
   end

   always @(posedge forever_cpuclk) begin
      if (cp0_pmp_wreg) begin
         wreg_cnt <= wreg_cnt + 1;
         if (cp0_pmp_reg_num == 5'h00) f_cfg0 <= cp0_pmp_wdata;
         else if (cp0_pmp_reg_num == 5'h02) f_cfg2 <= cp0_pmp_wdata;
         else if (cp0_pmp_reg_num[4:3] == 2'b10) f_addr[cp0_pmp_reg_num[2:0]] <= cp0_pmp_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, required end before 500000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] cfg_word(input int base);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = m_cfg[base+b];
      return w;
   endfunction

   task automatic set_cfg(input int base, input logic [63:0] w);
      for (int b = 0; b < 8; b++) m_cfg[base+b] = w[8*b +: 8];
      if (base == 0) f_cfg0 <= w;
      else f_cfg2 <= w;
   endtask

   task automatic set_addr(input int i, input logic [63:0] v);
      m_addr[i] = v;
      f_addr[i] <= v;
   endtask

   task automatic reseed();
      logic [7:0] b8;
      for (int e = 0; e < 16; e++) begin
         b8 = 8'($urandom);
         if ($urandom_range(0, 3) != 0) b8[7] = 1'b0;
         m_cfg[e] = b8;
      end
      f_cfg0 <= cfg_word(0);
      f_cfg2 <= cfg_word(8);
      for (int i = 0; i < 8; i++) set_addr(i, {$urandom, $urandom} & 64'h003F_FFFF_FFFF_FFFF);
   endtask

   // Expected outcome of one request, applied to the model state
   task automatic model_op(input logic [1:0] priv, input logic [1:0] op, input logic [11:0] addr,
                           input logic [63:0] src, output logic e_expt, output logic [63:0] e_rdata,
                           output int e_lat, output int e_wr);
      logic [63:0] old, nv;
      logic [7:0]  nb;
      logic        is_cfg, is_adr, lk;
      int          idx, base;
      is_cfg = (addr == 12'h3A0) || (addr == 12'h3A2);
      is_adr = (addr >= 12'h3B0) && (addr <= 12'h3BF);
      idx    = int'(addr[3:0]);
      base   = (addr == 12'h3A2) ? 8 : 0;
      e_wr   = 0;
      if (priv != 2'b11 || !(is_cfg || is_adr)) begin
         e_expt = 1'b1; e_rdata = '0; e_lat = 1;
         return;
      end
      e_expt = 1'b0;
      if (is_cfg) old = cfg_word(base);
      else old = (idx < 8) ? m_addr[idx] : 64'h0;
      e_rdata = old;
      if (op == 2'b00) begin
         e_lat = 2;
         return;
      end
      case (op)
         2'b01:   nv = src;
         2'b10:   nv = old | src;
         default: nv = old & ~src;
      endcase
      if (is_cfg) begin
         e_lat = 3; e_wr = 1;
         for (int b = 0; b < 8; b++) begin
            nb = nv[8*b +: 8] & 8'h9F;
            if (!m_cfg[base+b][7] && !(nb[1:0] == 2'b10)) m_cfg[base+b] = nb;
         end
      end else begin
         e_lat = 4;
         if (idx >= 8) return;
         e_wr = 1;
         lk = m_cfg[idx][7];
`ifdef CT_PMP_CSR_SEQ_TOR_LOCK_EN
         lk = lk || (m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'b01);
         if (idx == 7) e_lat = 5;
`endif
         if (!lk) m_addr[idx] = nv & 64'h003F_FFFF_FFFF_FFFF;
      end
   endtask

   task automatic do_op(input logic [1:0] priv, input logic [1:0] op, input logic [11:0] addr,
                        input logic [63:0] src);
      logic        e_expt;
      logic [63:0] e_rdata;
      int          e_lat, e_wr, lat, w0;
      chk("rdy_before", 64'(csr_iu_req_rdy), 64'd1);
      model_op(priv, op, addr, src, e_expt, e_rdata, e_lat, e_wr);
      cp0_yy_priv_mode = priv;
      iu_csr_op        = op;
      iu_csr_addr      = addr;
      iu_csr_src       = src;
      iu_csr_req_vld   = 1'b1;
      w0               = wreg_cnt;
      @(posedge forever_cpuclk); #1;
      iu_csr_req_vld = 1'b0;
      iu_csr_src     = {$urandom, $urandom};
      lat = 1;
      while (!csr_iu_done_vld && lat < 10) begin
         @(posedge forever_cpuclk); #1;
         lat++;
      end
      chk("done_latency", 64'(lat), 64'(e_lat));
      chk("rdata", csr_iu_rdata, e_rdata);
      chk("expt", 64'(csr_iu_expt), 64'(e_expt));
      @(posedge forever_cpuclk); #1;
      chk("done_one_cycle", 64'(csr_iu_done_vld), 64'd0);
      chk("wreg_count", 64'(wreg_cnt - w0), 64'(e_wr));
      chk("pmpcfg0", f_cfg0, cfg_word(0));
      chk("pmpcfg2", f_cfg2, cfg_word(8));
      for (int i = 0; i < 8; i++) chk("pmpaddr", f_addr[i], m_addr[i]);
   endtask

   initial begin
      int          w0;
      logic [11:0] a;
      logic [1:0]  p;
      cpurst_b = 1'b0; iu_csr_req_vld = 1'b0; cp0_yy_priv_mode = 2'b11;
      iu_csr_op = 2'b00; iu_csr_addr = '0; iu_csr_src = '0;
      reseed();
      repeat (3) @(posedge forever_cpuclk);
      #1;
      chk("reset_rdy", 64'(csr_iu_req_rdy), 64'd1);
      chk("reset_done", 64'(csr_iu_done_vld), 64'd0);
      chk("reset_expt", 64'(csr_iu_expt), 64'd0);
      chk("reset_wreg", 64'(cp0_pmp_wreg), 64'd0);
      chk("reset_rdata", csr_iu_rdata, 64'd0);
      chk("reset_wdata", cp0_pmp_wdata, 64'd0);
      chk("reset_reg_num", 64'(cp0_pmp_reg_num), 64'd0);
      cpurst_b = 1'b1;
      @(posedge forever_cpuclk); #1;

      // pmpaddr read
      set_addr(2, 64'h1234);
      do_op(2'b11, 2'b00, 12'h3B2, 64'h0);

      // pmpcfg0 RW: locked byte 0 kept, byte 7 loses bits 6:5
      set_cfg(0, 64'h0000_0000_0000_0080);
      do_op(2'b11, 2'b01, 12'h3A0, 64'hFF00_0000_0000_0081);
      chk("cfg0_rw_value", f_cfg0, 64'h9F00_0000_0000_0080);

      // RS on pmpaddr1 whose own entry is locked
      set_cfg(0, 64'h0000_0000_0000_8000);
      set_addr(1, 64'hABC);
      do_op(2'b11, 2'b10, 12'h3B1, 64'h10);
      chk("addr1_locked", f_addr[1], 64'hABC);

      // Illegal address and non-M privilege
      do_op(2'b11, 2'b01, 12'h3A1, 64'hFFFF);
      do_op(2'b00, 2'b01, 12'h3B0, 64'hFFFF);
      do_op(2'b11, 2'b00, 12'h3A3, 64'h0);

      // Entry 1 locked TOR protects pmpaddr0 only with the option
      set_cfg(0, 64'h0000_0000_0000_8800);
      set_addr(0, 64'h1111);
      do_op(2'b11, 2'b01, 12'h3B0, 64'h55);
`ifdef CT_PMP_CSR_SEQ_TOR_LOCK_EN
      chk("addr0_tor", f_addr[0], 64'h1111);
`else
      chk("addr0_tor", f_addr[0], 64'h55);
`endif

      // pmpaddr7 guarded by pmpcfg2 byte 0
      set_cfg(0, 64'h0);
      set_cfg(8, 64'h88);
      set_addr(7, 64'h777);
      do_op(2'b11, 2'b01, 12'h3B7, 64'h999);

      // Unimplemented pmpaddr: reads zero, write dropped
      do_op(2'b11, 2'b00, 12'h3B9, 64'h0);
      do_op(2'b11, 2'b01, 12'h3BC, 64'hFFFF);

      // Reset while reading the old value of a pmpcfg write
      set_cfg(0, 64'h0);
      cp0_yy_priv_mode = 2'b11; iu_csr_op = 2'b01; iu_csr_addr = 12'h3A0;
      iu_csr_src = 64'h0707_0707_0707_0707; iu_csr_req_vld = 1'b1;
      @(posedge forever_cpuclk); #1;
      iu_csr_req_vld = 1'b0;
      w0 = wreg_cnt;
      cpurst_b = 1'b0;
      @(posedge forever_cpuclk); #1;
      chk("rst_mid_rdy", 64'(csr_iu_req_rdy), 64'd1);
      chk("rst_mid_wreg", 64'(cp0_pmp_wreg), 64'd0);
      cpurst_b = 1'b1;
      repeat (3) begin
         @(posedge forever_cpuclk); #1;
         chk("rst_mid_no_done", 64'(csr_iu_done_vld), 64'd0);
      end
      chk("rst_mid_no_write", 64'(wreg_cnt - w0), 64'd0);
      chk("rst_mid_cfg0", f_cfg0, 64'h0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         if (n % 8 == 0) begin
            reseed();
            @(posedge forever_cpuclk); #1;
         end
         case ($urandom_range(0, 7))
            0:       a = 12'h3A0;
            1:       a = 12'h3A2;
            2, 3, 4: a = 12'h3B0 + 12'($urandom_range(0, 15));
            5:       a = 12'h3A1;
            6:       a = 12'h3A3;
            default: a = 12'($urandom);
         endcase
         p = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_op(p, 2'($urandom), a, {$urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
